conv_mem_host: RTL and testbench
================================

Name: conv_mem_host

Overview:
- Responder and host-side sequencer for the CONV accelerator's memory interface.
- Owns the image memory (4096x20) and the two layer memories: L0 (4096x20) and L1 (1024x20).
- Loads the image from a host stream, then kicks the accelerator with the ready/busy handshake.
- Services the accelerator's image reads and layer reads/writes, then streams both layers back to the host on completion.

Parameters:
- DW, 20, data word width (signed Q4.16 values, stored unchanged)
- IMG_AW, 12, image and L0 address width (64x64 map)
- L1_AW, 10, L1 address width (32x32 max-pooled map)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  host pulse; honoured only in IDLE
- load_valid  in  1  host image word valid
- load_ready  out  1  image word accepted this cycle
- load_data  in  DW  image word, raster order
- ready  out  1  kick to accelerator
- busy  in  1  accelerator busy
- iaddr  in  IMG_AW  image read address
- idata  out  DW  image read data
- cwr  in  1  layer write enable
- caddr_wr  in  IMG_AW  layer write address
- cdata_wr  in  DW  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  IMG_AW  layer read address
- cdata_rd  out  DW  layer read data
- csel  in  3  bank select: 1 = L0, 3 = L1, any other value = no bank
- dump_valid  out  1  result word valid
- dump_ready  in  1  host accepts result word
- dump_data  out  DW  result word
- dump_layer  out  1  0 = L0 word, 1 = L1 word
- dump_last  out  1  final L1 word
- done  out  1  one-cycle pulse when dump completes

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; counters go to 0.
  - ready, load_ready, dump_valid, dump_last, done all 0.
  - Memory contents are not reset and survive a reset.
- FSM states: IDLE, LOAD, KICK, RUN, DUMP0, DUMP1, FIN.
- IDLE: start=1 -> LOAD, and ld_cnt cleared.
- LOAD:
  - load_ready=1.
  - On load_valid&&load_ready, img[ld_cnt] <= load_data and ld_cnt increments.
  - After word 4095 is accepted -> KICK.
- KICK:
  - ready=1 and held until busy=1 is sampled.
  - Then -> RUN, with ready=0 in the same cycle as the transition.
  - If busy never rises, KICK holds indefinitely.
- RUN: waits for a busy falling edge (previous sample 1, current sample 0) -> DUMP0, with dump_ptr cleared.
- DUMP0:
  - dump_valid=1, dump_layer=0, dump_data=L0[dump_ptr].
  - dump_ptr advances on each dump_valid&&dump_ready.
  - After word 4095 -> DUMP1 with dump_ptr=0.
- DUMP1:
  - Same as DUMP0, but over L1[0..1023] with dump_layer=1.
  - dump_last=1 while dump_ptr=1023.
  - Accepted last word -> FIN.
- FIN: done=1 for one cycle -> IDLE.
- Dump handshake: while dump_valid&&!dump_ready, dump_data, dump_layer and dump_last stay stable.
- Accelerator-side servicing is active in every state:
  - idata = img[iaddr], combinational, zero-latency.
  - cdata_rd:
    - L0[caddr_rd] when crd&&csel==1.
    - L1[caddr_rd[L1_AW-1:0]] when crd&&csel==3.
    - Otherwise 0.
    - Combinational.
  - Writes are synchronous on the rising edge when cwr=1:
    - csel==1 -> L0[caddr_wr].
    - csel==3 -> L1[caddr_wr[L1_AW-1:0]].
    - Any other csel -> write dropped.
  - Read in the same cycle as a write to the same address returns the old data (read-before-write).
- Host load and accelerator traffic use separate arrays, so they never conflict.
- A start pulse outside IDLE is ignored.
- load_valid outside LOAD is ignored (load_ready=0).
- Reset asserted mid-LOAD or mid-DUMP returns to IDLE. Partially loaded or dumped data is not resumed; the host must restart.

Decomposition:
- Package conv_mem_pkg holds:
  - DW, IMG_AW, L1_AW.
  - CSEL_L0=3'd1, CSEL_L1=3'd3.
  - Image and L1 depths (4096, 1024).
  - FSM state encoding.
- Sub-module conv_sram (parameters DW, AW): asynchronous read, synchronous write with enable, no reset.
  - Instantiated three times: img, L0, L1.
  - The img instance's write port is driven from the load path.

Test Plan:
- Load ramp img[i]=i. Drive iaddr=0, 65, 4095 -> idata = 0x00000, 0x00041, 0x00FFF in the same cycle.
- After LOAD: ready=1 holds 5 cycles with busy=0, then busy=1 -> ready=0 next cycle and state RUN.
- In RUN:
  - cwr=1, csel=1, caddr_wr=100, cdata_wr=0x0ABCD -> next cycle crd=1, csel=1, caddr_rd=100 gives cdata_rd=0x0ABCD.
  - csel=3 with caddr_rd=100 gives the L1 value, not 0x0ABCD.
  - cwr=1 with csel=2 -> no array changes; crd=0 -> cdata_rd=0.
- Write L1[1023]=0xFFFFF, then drop busy:
  - Host dump_ready toggling 1,0,0,1 -> dump_data stable while stalled.
  - 4096 words with dump_layer=0, then 1024 words with dump_layer=1.
  - Final word 0xFFFFF with dump_last=1; done pulse one cycle later.
- Assert reset=0 at load word 2000 -> load_ready=0 and ready=0 immediately. Restart with start -> ld_cnt begins at 0 and the full 4096 words are required before ready rises.

Source files
------------

// File: rtl/conv_mem_pkg.sv
// -----------------------------------------------------------------------------
// conv_mem_pkg
// Shared constants and types for the CONV accelerator memory host:
//   - data/address widths and memory depths
//   - bank-select codes used on csel
//   - host sequencer FSM state encoding
// -----------------------------------------------------------------------------
package conv_mem_pkg;

    localparam int DW        = 20;   // signed Q4.16 word, stored unchanged
    localparam int IMG_AW    = 12;   // 64x64 image / L0 map
    localparam int L1_AW     = 10;   // 32x32 max-pooled map

    localparam int IMG_DEPTH = 4096;
    localparam int L1_DEPTH  = 1024;

    localparam logic [2:0] CSEL_L0 = 3'd1;
    localparam logic [2:0] CSEL_L1 = 3'd3;

    // Final indices expressed at the width of the shared counters.
    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_DEPTH - 1);
    localparam logic [IMG_AW-1:0] L1_LAST  = IMG_AW'(L1_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_KICK  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DUMP0 = 3'd4,
        ST_DUMP1 = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

endpackage

// File: rtl/conv_sram.sv
// -----------------------------------------------------------------------------
// conv_sram
// Simple memory with one synchronous write port and NRD asynchronous
// (combinational) read ports. Contents are never reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : NRD read addresses, packed, port gi at [gi*AW +: AW]
//   rdata  : NRD read data words, packed, port gi at [gi*DW +: DW]
// A read that coincides with a write to the same address returns the old
// word; the new word is visible after the clock edge.
// -----------------------------------------------------------------------------
module conv_sram #(
    parameter int DW  = 20,
    parameter int AW  = 12,
    parameter int NRD = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            assign rdata[gi*DW +: DW] = mem[raddr[gi*AW +: AW]];
        end
    endgenerate

endmodule

// File: rtl/conv_mem_host.sv
// -----------------------------------------------------------------------------
// conv_mem_host
// Host-side sequencer and memory responder for the CONV accelerator.
// Owns the image memory and the L0/L1 layer memories. Loads the image from
// a host stream, kicks the accelerator, services its memory traffic, and
// finally streams L0 then L1 back to the host.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start               : host start pulse (only honoured in IDLE)
//   load_valid/ready/data : host image stream, raster order
//   ready, busy         : accelerator kick / busy handshake
//   iaddr, idata        : accelerator image read (combinational)
//   cwr, caddr_wr, cdata_wr : accelerator layer write
//   crd, caddr_rd, cdata_rd : accelerator layer read (combinational)
//   csel                : layer bank select (1 = L0, 3 = L1)
//   dump_valid/ready/data/layer/last : result stream to host
//   done                : one-cycle pulse after the final L1 word
// -----------------------------------------------------------------------------
module conv_mem_host
    import conv_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DW-1:0]     load_data,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    input  logic [2:0]        csel,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DW-1:0]     dump_data,
    output logic              dump_layer,
    output logic              dump_last,
    output logic              done
);

    state_e            state_q, state_d;
    logic [IMG_AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [IMG_AW-1:0] dump_ptr_q, dump_ptr_d;
    logic              busy_prev_q;
    logic              load_ready_q, load_ready_d;
    logic              ready_q, ready_d;
    logic              dump_valid_q, dump_valid_d;
    logic              dump_layer_q, dump_layer_d;
    logic              dump_last_q, dump_last_d;
    logic              done_q, done_d;

    logic load_fire;
    logic dump_fire;

    assign load_fire = (state_q == ST_LOAD) && load_valid && load_ready_q;
    assign dump_fire = dump_valid_q && dump_ready;

    // ------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------
    logic              l0_we, l1_we;
    logic [2*DW-1:0]   l0_rdata, l1_rdata;
    logic [DW-1:0]     l0_rd_acc, l0_rd_dump, l1_rd_acc, l1_rd_dump;

    assign l0_we = cwr && (csel == CSEL_L0);
    assign l1_we = cwr && (csel == CSEL_L1);

    conv_sram #(.DW(DW), .AW(IMG_AW), .NRD(1)) u_img (
        .clk   (clk),
        .we    (load_fire),
        .waddr (ld_cnt_q),
        .wdata (load_data),
        .raddr (iaddr),
        .rdata (idata)
    );

    // Port 0 serves the accelerator, port 1 serves the host dump.
    conv_sram #(.DW(DW), .AW(IMG_AW), .NRD(2)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr ({dump_ptr_q, caddr_rd}),
        .rdata (l0_rdata)
    );

    conv_sram #(.DW(DW), .AW(L1_AW), .NRD(2)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr ({dump_ptr_q[L1_AW-1:0], caddr_rd[L1_AW-1:0]}),
        .rdata (l1_rdata)
    );

    assign l0_rd_acc  = l0_rdata[DW-1:0];
    assign l0_rd_dump = l0_rdata[2*DW-1:DW];
    assign l1_rd_acc  = l1_rdata[DW-1:0];
    assign l1_rd_dump = l1_rdata[2*DW-1:DW];

    always_comb begin
        cdata_rd = '0;
        if (crd && (csel == CSEL_L0)) begin
            cdata_rd = l0_rd_acc;
        end else if (crd && (csel == CSEL_L1)) begin
            cdata_rd = l1_rd_acc;
        end
    end

    // Pointer and layer are registered and only move on an accepted word,
    // so the dump word is stable across host stalls.
    assign dump_data = dump_layer_q ? l1_rd_dump : l0_rd_dump;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        dump_ptr_d = dump_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    ld_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_fire) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == IMG_LAST) begin
                        state_d = ST_KICK;
                    end
                end
            end
            ST_KICK: begin
                if (busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Accelerator finished: busy falling edge.
                if (busy_prev_q && !busy) begin
                    state_d    = ST_DUMP0;
                    dump_ptr_d = '0;
                end
            end
            ST_DUMP0: begin
                if (dump_fire) begin
                    if (dump_ptr_q == IMG_LAST) begin
                        state_d    = ST_DUMP1;
                        dump_ptr_d = '0;
                    end else begin
                        dump_ptr_d = dump_ptr_q + 1'b1;
                    end
                end
            end
            ST_DUMP1: begin
                if (dump_fire) begin
                    if (dump_ptr_q == L1_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        dump_ptr_d = dump_ptr_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they change exactly
        // with the state transition and come straight from flops.
        load_ready_d = (state_d == ST_LOAD);
        ready_d      = (state_d == ST_KICK);
        dump_valid_d = (state_d == ST_DUMP0) || (state_d == ST_DUMP1);
        dump_layer_d = (state_d == ST_DUMP1);
        dump_last_d  = (state_d == ST_DUMP1) && (dump_ptr_d == L1_LAST);
        done_d       = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ld_cnt_q     <= '0;
            dump_ptr_q   <= '0;
            busy_prev_q  <= 1'b0;
            load_ready_q <= 1'b0;
            ready_q      <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_layer_q <= 1'b0;
            dump_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            dump_ptr_q   <= dump_ptr_d;
            busy_prev_q  <= busy;
            load_ready_q <= load_ready_d;
            ready_q      <= ready_d;
            dump_valid_q <= dump_valid_d;
            dump_layer_q <= dump_layer_d;
            dump_last_q  <= dump_last_d;
            done_q       <= done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign ready      = ready_q;
    assign dump_valid = dump_valid_q;
    assign dump_layer = dump_layer_q;
    assign dump_last  = dump_last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conv_mem_host.sv
module tb_conv_mem_host;
    import conv_mem_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic              load_valid;
    logic              load_ready;
    logic [DW-1:0]     load_data;
    logic              ready;
    logic              busy;
    logic [IMG_AW-1:0] iaddr;
    logic [DW-1:0]     idata;
    logic              cwr;
    logic [IMG_AW-1:0] caddr_wr;
    logic [DW-1:0]     cdata_wr;
    logic              crd;
    logic [IMG_AW-1:0] caddr_rd;
    logic [DW-1:0]     cdata_rd;
    logic [2:0]        csel;
    logic              dump_valid;
    logic              dump_ready;
    logic [DW-1:0]     dump_data;
    logic              dump_layer;
    logic              dump_last;
    logic              done;

    int vectors;
    int miscompares;

    conv_mem_host dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ready      (ready),
        .busy       (busy),
        .iaddr      (iaddr),
        .idata      (idata),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .csel       (csel),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_layer (dump_layer),
        .dump_last  (dump_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are
    // sampled a further unit later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat_l0(input int i);
        pat_l0 = DW'((i * 7 + 3) & 20'hFFFFF);
    endfunction

    function automatic logic [DW-1:0] pat_l1(input int i);
        if (i == 1023) pat_l1 = 20'hFFFFF;
        else           pat_l1 = DW'(((i << 8) | 8'h5A) & 20'hFFFFF);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = DW'(base + i);
            tick();
        end
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({load_ready, ready, dump_valid, dump_last, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {load_ready, ready, dump_valid, dump_last, done});
        end
        vectors++;
        if (dut.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        tick();
        reset = 1'b1;
        tick();
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_load();
        pulse_start();
        #1;
        vectors++;
        if (load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_ready_rise: got %b expected 1", load_ready);
        end
        load_words(4095, 0);
        #1;
        vectors++;
        if (ready !== 1'b0 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_4095: ready=%b load_ready=%b expected 0/1", ready, load_ready);
        end
        load_words(1, 4095);
        #1;
        vectors++;
        if (ready !== 1'b1 || load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done: ready=%b load_ready=%b expected 1/0", ready, load_ready);
        end
        $display("load: 4096 ramp words streamed");
    endtask

    task automatic test_image_read();
        logic [IMG_AW-1:0] addrs [3];
        logic [DW-1:0]     exps  [3];
        addrs[0] = 12'd0;    exps[0] = 20'h00000;
        addrs[1] = 12'd65;   exps[1] = 20'h00041;
        addrs[2] = 12'd4095; exps[2] = 20'h00FFF;
        for (int k = 0; k < 3; k++) begin
            iaddr = addrs[k];
            #1;
            vectors++;
            if (idata !== exps[k]) begin
                miscompares++;
                $display("FAIL idata[%0d]: got %h expected %h", addrs[k], idata, exps[k]);
            end
            $display("image_read: iaddr=%0d idata=%h", addrs[k], idata);
        end
    endtask

    task automatic test_kick();
        busy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (ready !== 1'b1) begin
                miscompares++;
                $display("FAIL kick_hold cycle %0d: got %b expected 1", c, ready);
            end
        end
        busy = 1'b1;
        tick();
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL kick_drop: got %b expected 0", ready);
        end
        vectors++;
        if (dut.state_q !== ST_RUN) begin
            miscompares++;
            $display("FAIL kick_state: got %0d expected %0d", dut.state_q, ST_RUN);
        end
        $display("kick: ready held 5 cycles, dropped on busy");
    endtask

    task automatic test_run_ignores();
        pulse_start();
        load_valid = 1'b1;
        load_data  = 20'h77777;
        tick();
        load_valid = 1'b0;
        iaddr = 12'd0;
        #1;
        vectors++;
        if (load_ready !== 1'b0 || dut.state_q !== ST_RUN) begin
            miscompares++;
            $display("FAIL run_ignore_start: load_ready=%b state=%0d expected 0/%0d",
                     load_ready, dut.state_q, ST_RUN);
        end
        vectors++;
        if (idata !== 20'h00000) begin
            miscompares++;
            $display("FAIL run_ignore_load: idata[0]=%h expected 00000", idata);
        end
        $display("run_ignores: start and load_valid ignored in RUN");
    endtask

    task automatic test_layer_rw();
        // L0 write then read back
        cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd100; cdata_wr = 20'h0ABCD;
        tick();
        cwr = 1'b0; crd = 1'b1; csel = 3'd1; caddr_rd = 12'd100;
        #1;
        vectors++;
        if (cdata_rd !== 20'h0ABCD) begin
            miscompares++;
            $display("FAIL l0_rw: got %h expected 0abcd", cdata_rd);
        end
        $display("layer_rw: L0[100] read %h", cdata_rd);
        // Read-before-write on the same address
        cwr = 1'b1; caddr_wr = 12'd100; cdata_wr = 20'h11111;
        #1;
        vectors++;
        if (cdata_rd !== 20'h0ABCD) begin
            miscompares++;
            $display("FAIL l0_rbw_old: got %h expected 0abcd", cdata_rd);
        end
        tick();
        cwr = 1'b0;
        #1;
        vectors++;
        if (cdata_rd !== 20'h11111) begin
            miscompares++;
            $display("FAIL l0_rbw_new: got %h expected 11111", cdata_rd);
        end
        // L1 holds its own value at the same address
        cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd100; cdata_wr = 20'h12345;
        tick();
        cwr = 1'b0; crd = 1'b1; csel = 3'd3; caddr_rd = 12'd100;
        #1;
        vectors++;
        if (cdata_rd !== 20'h12345) begin
            miscompares++;
            $display("FAIL l1_rw: got %h expected 12345", cdata_rd);
        end
        // L1 ignores upper address bits
        caddr_rd = 12'd1124;
        #1;
        vectors++;
        if (cdata_rd !== 20'h12345) begin
            miscompares++;
            $display("FAIL l1_alias: got %h expected 12345", cdata_rd);
        end
        $display("layer_rw: L1[100] read %h", cdata_rd);
        // csel=2 write is dropped in both banks
        cwr = 1'b1; csel = 3'd2; caddr_wr = 12'd100; cdata_wr = 20'h22222;
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd100; csel = 3'd1;
        #1;
        vectors++;
        if (cdata_rd !== 20'h11111) begin
            miscompares++;
            $display("FAIL csel2_l0: got %h expected 11111", cdata_rd);
        end
        csel = 3'd3;
        #1;
        vectors++;
        if (cdata_rd !== 20'h12345) begin
            miscompares++;
            $display("FAIL csel2_l1: got %h expected 12345", cdata_rd);
        end
        csel = 3'd2;
        #1;
        vectors++;
        if (cdata_rd !== 20'h00000) begin
            miscompares++;
            $display("FAIL csel2_rd: got %h expected 00000", cdata_rd);
        end
        crd = 1'b0; csel = 3'd1;
        #1;
        vectors++;
        if (cdata_rd !== 20'h00000) begin
            miscompares++;
            $display("FAIL crd0: got %h expected 00000", cdata_rd);
        end
        $display("layer_rw: csel=2 dropped, crd=0 reads zero");
    endtask

    task automatic fill_layers();
        cwr = 1'b1; csel = 3'd1;
        for (int i = 0; i < IMG_DEPTH; i++) begin
            caddr_wr = IMG_AW'(i); cdata_wr = pat_l0(i);
            tick();
        end
        csel = 3'd3;
        for (int i = 0; i < L1_DEPTH; i++) begin
            caddr_wr = IMG_AW'(i); cdata_wr = pat_l1(i);
            tick();
        end
        cwr = 1'b0; csel = 3'd0;
        $display("fill: L0 and L1 written with reference patterns");
    endtask

    task automatic test_dump();
        int idx;
        int cyc;
        logic [3:0]    first_rdy;
        logic [DW-1:0] exp_data;
        logic          exp_layer;
        logic          exp_last;
        first_rdy = 4'b1001; // bit c = dump_ready in cycle c: 1,0,0,1
        idx = 0;
        cyc = 0;
        busy = 1'b0;
        tick();
        while (idx < 5120 && cyc < 12000) begin
            if (cyc < 4) dump_ready = first_rdy[cyc];
            else         dump_ready = ((cyc % 29) != 5);
            #1;
            exp_layer = (idx >= 4096);
            exp_data  = exp_layer ? pat_l1(idx - 4096) : pat_l0(idx);
            exp_last  = (idx == 5119);
            vectors++;
            if (dump_valid !== 1'b1 || dump_layer !== exp_layer ||
                dump_data !== exp_data || dump_last !== exp_last) begin
                miscompares++;
                $display("FAIL dump_word %0d: valid=%b layer=%b data=%h last=%b expected 1/%b/%h/%b",
                         idx, dump_valid, dump_layer, dump_data, dump_last,
                         exp_layer, exp_data, exp_last);
            end
            if (cyc < 4) begin
                $display("dump: cycle %0d ready=%b word %0d data=%h", cyc, dump_ready, idx, dump_data);
            end
            if (dump_ready) idx++;
            cyc++;
            tick();
        end
        dump_ready = 1'b0;
        vectors++;
        if (idx != 5120) begin
            miscompares++;
            $display("FAIL dump_timeout: accepted %0d words expected 5120", idx);
        end
        #1;
        vectors++;
        if (done !== 1'b1 || dump_valid !== 1'b0 || dump_last !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b valid=%b last=%b expected 1/0/0", done, dump_valid, dump_last);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || dut.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL done_clear: done=%b state=%0d expected 0/%0d", done, dut.state_q, ST_IDLE);
        end
        $display("dump: %0d words in %0d cycles, done pulsed", idx, cyc);
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        load_words(2000, 20'h10000);
        load_valid = 1'b1;
        reset = 1'b0;
        #1;
        vectors++;
        if (load_ready !== 1'b0 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_reset: load_ready=%b ready=%b expected 0/0", load_ready, ready);
        end
        load_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        load_words(4095, 20'h20000);
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_4095: ready=%b expected 0", ready);
        end
        load_words(1, 20'h20000 + 4095);
        #1;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_done: ready=%b expected 1", ready);
        end
        iaddr = 12'd0;
        #1;
        vectors++;
        if (idata !== 20'h20000) begin
            miscompares++;
            $display("FAIL restart_img0: got %h expected 20000", idata);
        end
        iaddr = 12'd2001;
        #1;
        vectors++;
        if (idata !== 20'h207D1) begin
            miscompares++;
            $display("FAIL restart_img2001: got %h expected 207d1", idata);
        end
        $display("reset_mid_load: restart reloaded from word 0");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        busy       = 1'b0;
        iaddr      = '0;
        cwr        = 1'b0;
        caddr_wr   = '0;
        cdata_wr   = '0;
        crd        = 1'b0;
        caddr_rd   = '0;
        csel       = 3'd0;
        dump_ready = 1'b0;

        test_reset();
        test_load();
        test_image_read();
        test_kick();
        test_run_ignores();
        test_layer_rw();
        fill_layers();
        test_dump();
        test_reset_mid_load();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
